dmem_access_ctrl: RTL and testbench

MEM-stage data-memory access controller for the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and supplies the load-data word the MEM/WB register captures as its memory result. It turns the single-cycle `mem_read`/`mem_write` controls into a req/ack transaction on a variable-latency data bus. While a transaction is outstanding it holds the upstream pipeline with `stall`, and it reports bus timeouts through a sticky error flag.

---
 rtl/dmem_access_ctrl.sv | 96 +++++++++
 tb/tb_dmem_access_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: converts single-cycle load/store
// controls into a req/ack bus transaction, stalling the pipeline until it completes.
module dmem_access_ctrl #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] mem_out,
  output logic                stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_LEN-1:0] bus_addr,
  output logic [WORD_LEN-1:0] bus_wdata,
  input  logic                bus_ack,
  input  logic [WORD_LEN-1:0] bus_rdata,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] count;
  logic       req;
  logic       timeout_hit;

  assign req         = mem_read | mem_write;
  assign timeout_hit = (state == WAIT) && !bus_ack && (count == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // stall is masked by rst so the pipeline never freezes while reset is held
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = req & ~rst;
        if (req) state_next = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_ack || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_out   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            bus_addr  <= addr & ~ADDR_LEN'(3);
            bus_wdata <= wdata;
            bus_we    <= mem_write;
            bus_req   <= 1'b1;
            count     <= '0;
          end
        end
        WAIT: begin
          // an ack arriving on the last allowed cycle still completes normally
          if (bus_ack) begin
            if (!bus_we) mem_out <= bus_rdata;
            bus_req <= 1'b0;
          end else if (timeout_hit) begin
            if (!bus_we) mem_out <= WORD_LEN'(32'hDEADBEEF);
            err     <= 1'b1;
            bus_req <= 1'b0;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl; a transaction-level model predicts
// stall length, bus activity, load result and sticky error.
module tb_dmem_access_ctrl;
  localparam int W = 32;
  localparam int A = 32;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [A-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] mem_out;
  logic         stall;
  logic         bus_req, bus_we;
  logic [A-1:0] bus_addr;
  logic [W-1:0] bus_wdata;
  logic         bus_ack;
  logic [W-1:0] bus_rdata;
  logic         err;

  dmem_access_ctrl #(.WORD_LEN(W), .ADDR_LEN(A), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .mem_out(mem_out), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          issue_cnt = 0;
  logic        req_q = 1'b0;
  logic [31:0] m_mem_out;
  bit          m_err;

  // counts rising edges of bus_req, i.e. transactions put on the bus
  always @(negedge clk) begin
    if (bus_req && !req_q) issue_cnt <= issue_cnt + 1;
    req_q <= bus_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One memory instruction; lat = index of the bus_req cycle carrying the ack,
  // lat > T means the memory never answers.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int lat, input bit spur);
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    int          cyc       = 0;
    bit          fin       = 0;
    bit          to        = (lat > T);
    int          exp_wait  = to ? T : lat;
    logic [31:0] exp_addr  = a & 32'hFFFF_FFFC;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    #1;
    while (!fin && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      if (stall) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_we", 32'(bus_we), 32'(wr));
        if (wr) chk("bus_wdata", bus_wdata, wd);
        bus_ack   = (req_cnt == lat);
        bus_rdata = bus_ack ? rdat : $urandom;
      end else if (!stall && cyc > 0) begin
        fin = 1;
        if (rd && !wr) m_mem_out = to ? 32'hDEADBEEF : rdat;
        if (to) m_err = 1;
        chk("mem_out", mem_out, m_mem_out);
        chk("err", 32'(err), 32'(m_err));
        mem_read  = 0;
        mem_write = 0;
        bus_ack   = spur;
        bus_rdata = $urandom;
      end else if (cyc > 0) begin
        bus_ack = 0;
      end
      cyc++;
    end
    if (!fin) chk("txn_completes", 32'(fin), 32'd1);
    chk("stall_cycles", 32'(stall_cnt), 32'(1 + exp_wait));
    chk("req_cycles", 32'(req_cnt), 32'(exp_wait));
    $display("[TB] txn rd=%0d wr=%0d addr=%h lat=%0d stall=%0d req=%0d mem_out=%h err=%0d",
             rd, wr, a, lat, stall_cnt, req_cnt, mem_out, err);
  endtask

  task automatic rand_txn();
    int r = $urandom_range(0, 2);
    do_txn(r != 1, r != 0, $urandom, $urandom, $urandom,
           $urandom_range(1, T + 2), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1; mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    m_mem_out = 0; m_err = 0;

    @(negedge clk);
    mem_read = 1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    mem_read = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_bus_req", 32'(bus_req), 32'd0);

    do_txn(1, 0, 32'h1003, 32'h0, 32'hCAFEF00D, 1, 0);
    do_txn(0, 1, 32'h20, 32'h12345678, 32'h0, 4, 0);
    do_txn(1, 1, 32'h37, 32'hA5A5_5A5A, 32'h0, 2, 0);
    do_txn(1, 0, 32'h44, 32'h0, 32'h0, T + 3, 0);
    do_txn(1, 0, 32'h48, 32'h0, 32'h0BADF00D, 2, 0);

    base = issue_cnt;
    do_txn(1, 0, 32'h100, 32'h0, 32'h1111_2222, 2, 1);
    do_txn(0, 1, 32'h104, 32'h3333_4444, 32'h0, 1, 1);
    repeat (3) begin
      @(negedge clk);
      chk("post_b2b_stall", 32'(stall), 32'd0);
      chk("post_b2b_req", 32'(bus_req), 32'd0);
      bus_ack = 0;
    end
    chk("b2b_issues", 32'(issue_cnt - base), 32'd2);
    chk("b2b_mem_out", mem_out, m_mem_out);

    repeat (30) rand_txn();

    bus_ack = 0; mem_read = 1; mem_write = 0; addr = 32'h80;
    @(negedge clk);
    chk("rst_test_issue_stall", 32'(stall), 32'd1);
    @(negedge clk);
    chk("rst_test_wait_req", 32'(bus_req), 32'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_bus_req", 32'(bus_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_mem_out", mem_out, 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    mem_read = 0;
    rst = 0;
    m_mem_out = 0;
    m_err = 0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_stall", 32'(stall), 32'd0);
      chk("post_rst_req", 32'(bus_req), 32'd0);
    end

    repeat (8) rand_txn();
    @(negedge clk);
    bus_ack = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
